// File: rtl/out_port_arbiter_if.sv
// Handshake bundle between the input channels, the output port arbiter and downstream.
// master drives channel flits and out_ready; slave (the arbiter) drives readies, output flit and grant.
interface out_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;
  logic [NUM_IN-1:0]       grant;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant
  );
endinterface

// File: rtl/out_port_arbiter.sv
// Packet-locked output port arbiter: round-robin by default, fixed priority (lowest index)
// when OUT_PORT_ARB_FIXED_PRIO_EN is defined. One registered output flit stage.
module out_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5
) (
  input  logic              clk,
  input  logic              rst,
  out_port_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_r;
  logic [NUM_IN-1:0] grant_r;
  logic [IDX_W-1:0]  owner_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              out_valid_r;
  logic              out_last_r;

  logic [IDX_W-1:0]  start_s;
  logic [IDX_W-1:0]  idx_s;
  logic [IDX_W-1:0]  winner_s;
  logic              found_s;
  logic [NUM_IN-1:0] winner_oh_s;
  logic [NUM_IN-1:0] in_ready_s;
  logic              out_free_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  flit_data_s;
  logic              flit_last_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_IN - 1)) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

`ifdef OUT_PORT_ARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [IDX_W-1:0] rr_ptr_r;
  assign start_s = rr_ptr_r;
`endif

  // Winner search: first requesting channel starting at start_s, wrapping modulo NUM_IN.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = start_s;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found_s && bus.in_valid[idx_s]) begin
        winner_s = idx_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
      idx_s = next_idx(idx_s);
    end
  end

  assign winner_oh_s = {{(NUM_IN-1){1'b0}}, 1'b1} << winner_s;
  assign out_free_s  = !out_valid_r || bus.out_ready;

  // Only the locked owner may be ready, and only when the output stage can take a flit.
  always_comb begin
    if (!rst && (state_r == LOCKED)) begin
      in_ready_s = grant_r & {NUM_IN{out_free_s}};
    end else begin
      in_ready_s = '0;
    end
  end

  assign flit_data_s = bus.in_data[owner_r*WIDTH +: WIDTH];
  assign flit_last_s = bus.in_last[owner_r];
  assign xfer_s      = |(bus.in_valid & in_ready_s);

  // Arbitration FSM together with the registered output flit stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      owner_r     <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
`ifndef OUT_PORT_ARB_FIXED_PRIO_EN
      rr_ptr_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.in_valid) begin
            grant_r <= winner_oh_s;
            owner_r <= winner_s;
            state_r <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer_s && flit_last_s) begin
            state_r  <= IDLE;
            grant_r  <= '0;
`ifndef OUT_PORT_ARB_FIXED_PRIO_EN
            rr_ptr_r <= next_idx(owner_r);
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase

      // A new flit overwrites the stage even while it drains, keeping back-to-back throughput.
      if (xfer_s) begin
        out_data_r  <= flit_data_s;
        out_last_r  <= flit_last_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.grant     = grant_r;
endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: flit data width in bits.
REQ-002 SHALL have parameter NUM_IN, default 5: number of input channels, range 2..16.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  NUM_IN*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid  input  NUM_IN: channel i has a flit.
REQ-007 SHALL have port in_last  input  NUM_IN: channel i's flit is a packet tail.
REQ-008 SHALL have port in_ready  output  NUM_IN: channel i's flit is accepted this cycle.
REQ-009 SHALL have port out_data  output  WIDTH: registered output flit.
REQ-010 SHALL have port out_valid  output  1: out_data holds a flit.
REQ-011 SHALL have port out_last  output  1: the output flit is a tail.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the output flit.
REQ-013 SHALL have port grant  output  NUM_IN: one-hot current owner, all zero when idle.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-015 In IDLE with any in_valid high, SHALL select one winner, load grant, and enter LOCKED on the next edge; in_ready SHALL be all zero in IDLE.
REQ-016 In IDLE with no in_valid high, SHALL stay in IDLE with grant = 0.
REQ-017 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NUM_IN; the first valid index wins.
REQ-018 In LOCKED, in_ready[g] SHALL equal (!out_valid || out_ready) for the granted g, and in_ready SHALL be 0 for all other channels.
REQ-019 A transfer occurs when in_valid[g] && in_ready[g]; out_data/out_last SHALL load the flit on that edge and out_valid SHALL go high.
REQ-020 out_valid SHALL clear on an edge where out_valid && out_ready and no new transfer occurs; simultaneous drain and load SHALL keep out_valid high with the new flit.
REQ-021 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 A transfer with in_last high SHALL return the FSM to IDLE, clear grant, and set rr_ptr = (g+1) mod NUM_IN on the same edge.
REQ-023 A single-flit packet (in_last on its first flit) SHALL be handled as a complete packet.
REQ-024 Flits of different packets SHALL never interleave on the output; the lock holds regardless of other channels' in_valid.
REQ-025 Latency: request in IDLE at cycle N gives grant at N+1; the first flit transfers at N+1 and appears on out_valid at N+2; sustained throughput is 1 flit/cycle with out_ready high.
REQ-026 A new arbitration SHALL NOT start until the cycle after the tail transfer; the inter-packet bubble is one cycle.
REQ-027 in_valid dropping while LOCKED SHALL stall without losing the lock.

Reset
REQ-028 With rst high at an edge: FSM = IDLE, grant = 0, rr_ptr = 0, out_valid = 0, out_last = 0, out_data = 0.
REQ-029 Reset mid-packet SHALL abandon the packet; the next arbitration starts from rr_ptr = 0.
REQ-030 in_ready SHALL be 0 during any cycle in which rst is high.

Configuration
REQ-031 Macro OUT_PORT_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (lowest index wins), rr_ptr SHALL not exist or not update, and all other behaviour SHALL be unchanged.
REQ-032 When OUT_PORT_ARB_FIXED_PRIO_EN is not defined, round-robin per REQ-017/REQ-022 SHALL apply.

Verification
REQ-033 Scenario: NUM_IN=5, ch2 sends a 3-flit packet A,B,C (C last), out_ready=1 -> grant=5'b00100 at cycle 1; out A,B,C at cycles 2-4; out_last only with C; grant=0 at cycle 4.
REQ-034 Scenario: ch0 and ch3 both valid continuously with 1-flit packets -> grants alternate ch0,ch3,ch0,ch3 (round-robin); with the macro defined -> ch0 always wins.
REQ-035 Scenario: out_ready=0 for 3 cycles mid-packet -> out_data held constant, in_ready[g]=0, no flit lost or duplicated once out_ready rises.
REQ-036 Scenario: ch1 locked mid-packet, ch4 asserts valid -> ch4 in_ready stays 0 until ch1's tail transfers, then ch4 is granted the cycle after the bubble.
REQ-037 Scenario: rst asserted during the 2nd flit of a packet -> next cycle out_valid=0, grant=0; a subsequent request from ch3 with ch0 also valid -> ch0 wins (rr_ptr=0).
REQ-038 Scenario: random traffic on all 5 channels, random out_ready, 10k cycles -> scoreboard confirms per-packet ordering, no interleaving, no loss.
